// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU (SUB/ADD/LSL/NEG/LSR, optional MUL).
// Results, flags and err are registered; in_ready decodes the FSM state only.
// Optional feature macro: ALU_SEQ_MUL_EN -- when defined, opcode 101 runs an
// iterative shift-add multiplier (WIDTH cycles); when undefined it is illegal.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; a producer holds its payload stable while valid is high and ready low.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam logic [2:0] OP_SUB = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_LSL = 3'b010;
  localparam logic [2:0] OP_NEG = 3'b011;
  localparam logic [2:0] OP_LSR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] MIN_V   = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL_BUSY = 2'd1, DONE = 2'd2} state_t;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             err_q;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  // Single-cycle datapath: result and flags for the operation at the inputs.
  logic [WIDTH:0]   add_w, sub_w, lsl_w, lsr_w;
  logic [WIDTH-1:0] neg_w;
  logic [SHW-1:0]   sh;
  logic             shift_big;
  logic [WIDTH-1:0] alu_res_d;
  logic             alu_c_d, alu_v_d, alu_ill_d;
  logic [3:0]       alu_flags_d;
  logic             is_mul;

  // Combinational evaluation of every single-cycle opcode.
  always_comb begin
    add_w     = {1'b0, src_a} + {1'b0, src_b};
    sub_w     = {1'b0, src_a} - {1'b0, src_b};
    neg_w     = '0 - src_a;
    sh        = src_b[SHW-1:0];
    shift_big = (src_b >= WIDTH_V);
    // Widened shifts keep the last bit shifted out in the extra position.
    lsl_w     = {1'b0, src_a} << sh;
    lsr_w     = {src_a, 1'b0} >> sh;
    alu_res_d = '0;
    alu_c_d   = 1'b0;
    alu_v_d   = 1'b0;
    alu_ill_d = 1'b0;
    is_mul    = 1'b0;
    case (alu_op)
      OP_SUB: begin
        alu_res_d = sub_w[WIDTH-1:0];
        alu_c_d   = ~sub_w[WIDTH];
        alu_v_d   = (src_a[WIDTH-1] ^ src_b[WIDTH-1]) &
                    (sub_w[WIDTH-1] ^ src_a[WIDTH-1]);
      end
      OP_ADD: begin
        alu_res_d = add_w[WIDTH-1:0];
        alu_c_d   = add_w[WIDTH];
        alu_v_d   = ~(src_a[WIDTH-1] ^ src_b[WIDTH-1]) &
                    (add_w[WIDTH-1] ^ src_a[WIDTH-1]);
      end
      OP_LSL: begin
        if (!shift_big) begin
          alu_res_d = lsl_w[WIDTH-1:0];
          alu_c_d   = lsl_w[WIDTH];
        end
      end
      OP_NEG: begin
        alu_res_d = neg_w;
        alu_c_d   = (src_a == '0);
        alu_v_d   = (src_a == MIN_V);
      end
      OP_LSR: begin
        if (!shift_big) begin
          alu_res_d = lsr_w[WIDTH:1];
          alu_c_d   = lsr_w[0];
        end
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: is_mul = 1'b1;
`endif
      default: alu_ill_d = 1'b1;
    endcase
    if (alu_ill_d) alu_flags_d = 4'b0000;
    else alu_flags_d = {alu_res_d[WIDTH-1], (alu_res_d == '0), alu_c_d, alu_v_d};
  end

`ifdef ALU_SEQ_MUL_EN
  // Shift-add multiplier: multiplier bits live in the low half of acc_q and
  // are consumed LSB first while partial sums accumulate in the high half.
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]     cnt_q;
  logic [WIDTH:0]     mul_sum;
  logic               mul_hi_nz;

  // One multiplier iteration: conditional add, then shift right by one.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    acc_d     = {mul_sum, acc_q[WIDTH-1:1]};
    mul_hi_nz = (acc_d[2*WIDTH-1:WIDTH] != '0);
  end
`endif

  // Control FSM with registered result, flags, err and out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
            if (is_mul) begin
              mcand_q <= src_a;
              acc_q   <= {{WIDTH{1'b0}}, src_b};
              cnt_q   <= '0;
              state_q <= MUL_BUSY;
            end else begin
              result_q    <= alu_res_d;
              flags_q     <= alu_flags_d;
              err_q       <= alu_ill_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
`else
            result_q    <= alu_res_d;
            flags_q     <= alu_flags_d;
            err_q       <= alu_ill_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`endif
          end
        end
`ifdef ALU_SEQ_MUL_EN
        MUL_BUSY: begin
          acc_q <= acc_d;
          if (cnt_q == CNT_LAST) begin
            result_q    <= acc_d[WIDTH-1:0];
            flags_q     <= {acc_d[WIDTH-1], (acc_d[WIDTH-1:0] == '0),
                            mul_hi_nz, mul_hi_nz};
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
